// File: rtl/addr_gen_queue_if.sv
// Issue-side and LSB-side handshake bundle for the load/store address-generation queue.
// The slave view belongs to the queue; the master view to whoever drives it.
interface addr_gen_queue_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 3,
  parameter int OP_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  offset;
  logic [OP_W-1:0]  op_in;
  logic [ROB_W-1:0] rob_in;
  logic [XLEN-1:0]  st_data_in;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_addr;
  logic [OP_W-1:0]  out_op;
  logic [ROB_W-1:0] out_rob;
  logic [XLEN-1:0]  out_st_data;
  logic             out_misalign;

  modport master (
    output in_valid, base, offset, op_in, rob_in, st_data_in, out_ready,
    input  in_ready, out_valid, out_addr, out_op, out_rob, out_st_data, out_misalign
  );

  modport slave (
    input  in_valid, base, offset, op_in, rob_in, st_data_in, out_ready,
    output in_ready, out_valid, out_addr, out_op, out_rob, out_st_data, out_misalign
  );
endinterface

// File: rtl/addr_gen_queue.sv
// Load/store address generation (base + offset, misalignment flag) feeding a DEPTH-entry
// FIFO toward the load/store buffer; the head entry is held in output registers.
module addr_gen_queue #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 3,
  parameter int OP_W  = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  addr_gen_queue_if.slave            io_agq,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  st_data;
    logic             misalign;
  } entry_t;

  localparam int                  ENTRY_W  = $bits(entry_t);
  localparam logic [PTR_W-1:0]    PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);

  // Size 11 is reserved and always reported as misaligned so the LSB traps it.
  function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] lsb);
    logic result;
    case (size)
      2'b00:   result = 1'b0;
      2'b01:   result = lsb[0];
      2'b10:   result = (lsb != 2'b00);
      default: result = 1'b1;
    endcase
    return result;
  endfunction

  entry_t           r_mem [DEPTH];
  entry_t           r_head;
  logic             r_out_valid;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_addr;
  entry_t           w_new;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  entry_t           w_head_nxt;

  assign w_in_ready = rst & (r_count != CNT_FULL);
  assign w_push     = io_agq.in_valid & w_in_ready & ~i_flush;
  assign w_pop      = r_out_valid & io_agq.out_ready & ~i_flush;
  assign w_addr     = io_agq.base + io_agq.offset;

  // Build the entry that a push this cycle would store.
  always_comb begin
    w_new          = {ENTRY_W{1'b0}};
    w_new.addr     = w_addr;
    w_new.op       = io_agq.op_in;
    w_new.rob      = io_agq.rob_in;
    w_new.st_data  = io_agq.st_data_in;
    w_new.misalign = misalign_f(io_agq.op_in[1:0], w_addr[1:0]);
  end

  // Next read pointer, occupancy and head; a fresh push becomes head when it lands at the read slot.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_head_nxt   = {ENTRY_W{1'b0}};
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
    if (w_count_nxt == CNT_ZERO) begin
      w_head_nxt = {ENTRY_W{1'b0}};
    end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = w_new;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Entry storage; writes are already gated by reset and flush through w_push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // Pointers, occupancy and registered head; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_count     <= CNT_ZERO;
      r_out_valid <= 1'b0;
      r_head      <= {ENTRY_W{1'b0}};
    end else if (i_flush) begin
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_count     <= CNT_ZERO;
      r_out_valid <= 1'b0;
      r_head      <= {ENTRY_W{1'b0}};
    end else begin
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_ptr    <= w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != CNT_ZERO);
      r_head      <= w_head_nxt;
    end
  end

  assign io_agq.in_ready     = w_in_ready;
  assign io_agq.out_valid    = r_out_valid;
  assign io_agq.out_addr     = r_head.addr;
  assign io_agq.out_op       = r_head.op;
  assign io_agq.out_rob      = r_head.rob;
  assign io_agq.out_st_data  = r_head.st_data;
  assign io_agq.out_misalign = r_head.misalign;
  assign o_count             = r_count;

endmodule

// File: tb/tb_addr_gen_queue.sv
// Scoreboard bench for addr_gen_queue: expected entries are queued when a push is accepted
// and compared against the head outputs every cycle until popped.
module tb_addr_gen_queue;
  localparam int XLEN  = 32;
  localparam int ROB_W = 3;
  localparam int OP_W  = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic [XLEN-1:0]  addr;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  data;
    logic             mis;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  addr_gen_queue_if #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W)) agq ();

  addr_gen_queue #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_flush(flush),
    .io_agq (agq),
    .o_count(count)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_mis(input logic [31:0] a, input logic [4:0] op);
    case (op[1:0])
      2'd0:    return 1'b0;
      2'd1:    return (a % 32'd2) != 32'd0;
      2'd2:    return (a % 32'd4) != 32'd0;
      default: return 1'b1;
    endcase
  endfunction

  // One clock: predict push/pop from the driven inputs, advance the model, then check outputs.
  task automatic cycle();
    bit   do_push;
    bit   do_pop;
    exp_t e;
    do_push = rst && agq.in_valid && (sb.size() < DEPTH) && !flush;
    do_pop  = rst && (sb.size() != 0) && agq.out_ready && !flush;
    e.addr  = agq.base + agq.offset;
    e.op    = agq.op_in;
    e.rob   = agq.rob_in;
    e.data  = agq.st_data_in;
    e.mis   = exp_mis(e.addr, e.op);
    @(posedge clk);
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
    #1;
    check_val("count", 64'(count), 64'(sb.size()));
    check_val("in_ready", 64'(agq.in_ready), 64'(rst && (sb.size() != DEPTH)));
    check_val("out_valid", 64'(agq.out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_val("out_addr", 64'(agq.out_addr), 64'(sb[0].addr));
      check_val("out_op", 64'(agq.out_op), 64'(sb[0].op));
      check_val("out_rob", 64'(agq.out_rob), 64'(sb[0].rob));
      check_val("out_st_data", 64'(agq.out_st_data), 64'(sb[0].data));
      check_val("out_misalign", 64'(agq.out_misalign), 64'(sb[0].mis));
    end else begin
      check_val("out_addr_idle", 64'(agq.out_addr), 64'd0);
      check_val("out_misalign_idle", 64'(agq.out_misalign), 64'd0);
      check_val("out_rob_idle", 64'(agq.out_rob), 64'd0);
    end
  endtask

  task automatic drive(input logic [31:0] b, input logic [31:0] o, input logic [4:0] op,
                       input logic [2:0] rob, input logic [31:0] d);
    agq.in_valid   = 1'b1;
    agq.base       = b;
    agq.offset     = o;
    agq.op_in      = op;
    agq.rob_in     = rob;
    agq.st_data_in = d;
  endtask

  initial begin
    rst            = 1'b0;
    flush          = 1'b0;
    agq.out_ready  = 1'b0;
    drive(32'h0000_2000, 32'h0000_0010, 5'b00010, 3'd1, 32'hDEAD_BEEF);

    // Reset held two cycles with an op offered
    cycle();
    cycle();
    check_val("rst_count_abs", 64'(count), 64'd0);

    // Basic add, then drain
    rst = 1'b1;
    drive(32'h0000_1000, 32'h0000_0024, 5'b00010, 3'd5, 32'h1234_5678);
    cycle();
    check_val("t2_addr", 64'(agq.out_addr), 64'h1024);
    check_val("t2_rob", 64'(agq.out_rob), 64'd5);
    agq.in_valid  = 1'b0;
    agq.out_ready = 1'b1;
    cycle();
    check_val("t2_drained", 64'(count), 64'd0);

    // Wraparound and misalignment, streamed with out_ready high
    drive(32'hFFFF_FFFC, 32'h0000_0008, 5'b00010, 3'd2, 32'h0);
    cycle();
    check_val("t3_wrap", 64'(agq.out_addr), 64'h4);
    drive(32'h0000_1002, 32'h0, 5'b00010, 3'd3, 32'h1);
    cycle();
    check_val("t3_mis_word", 64'(agq.out_misalign), 64'd1);
    drive(32'h0000_1001, 32'h0, 5'b00001, 3'd4, 32'h2);
    cycle();
    check_val("t3_mis_half", 64'(agq.out_misalign), 64'd1);
    drive(32'h0000_1003, 32'h0, 5'b00000, 3'd6, 32'h3);
    cycle();
    check_val("t3_mis_byte", 64'(agq.out_misalign), 64'd0);
    drive(32'h0000_1000, 32'h0, 5'b00011, 3'd7, 32'h4);
    cycle();
    agq.in_valid = 1'b0;
    cycle();

    // Fill to full; fifth op held off, then drain in order
    agq.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h0000_4000 + 32'(i * 16), 32'(i), 5'(i % 4), 3'(i), 32'hA000_0000 + 32'(i));
      cycle();
    end
    check_val("t4_full_ready", 64'(agq.in_ready), 64'd0);
    agq.in_valid  = 1'b0;
    agq.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Simultaneous push and pop at count 2
    agq.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(32'h0000_5000, 32'(i * 4), 5'b00010, 3'(i), 32'(i));
      cycle();
    end
    agq.out_ready = 1'b1;
    drive(32'h0000_6000, 32'h8, 5'b00010, 3'd7, 32'h77);
    cycle();
    check_val("t5_count_same", 64'(count), 64'd2);
    agq.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Flush with an incoming op
    agq.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_7000, 32'(i), 5'b00000, 3'(i), 32'(i));
      cycle();
    end
    flush = 1'b1;
    cycle();
    check_val("t6_flushed", 64'(count), 64'd0);
    flush        = 1'b0;
    agq.in_valid = 1'b0;
    cycle();

    // Random traffic with occasional flush and one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      agq.in_valid   = 1'($urandom_range(0, 1));
      agq.out_ready  = 1'($urandom_range(0, 2) != 0);
      agq.base       = $urandom;
      agq.offset     = $urandom;
      agq.op_in      = 5'($urandom_range(0, 31));
      agq.rob_in     = 3'($urandom_range(0, 7));
      agq.st_data_in = $urandom;
      flush          = ($urandom_range(0, 19) == 0);
      rst            = (i != 200);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
